mmss_display: RTL and testbench
===============================

Name: mmss_display

Overview:
- Downstream consumer of the 1 Hz square wave from the board clock divider on the Basys 3.
- Counts elapsed seconds as a BCD minutes:seconds value from 00:00 to 59:59.
- Drives the board's 4-digit common-anode 7-segment display by time-multiplexing the anodes.
- The decimal point of the minutes-ones digit blinks as a colon, in phase with the 1 Hz input.

Parameters:
- REFRESH_COUNT, 100_000: clock cycles each digit stays lit (1 ms at 100 MHz, so 250 Hz per-digit refresh). Must be at least 2.
- RESET_DIGIT, 0: digit index selected after reset.

Ports:
- i_clk_100MHz  input  1  system clock; all logic is in this single domain.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_clk_1Hz  input  1  1 Hz, 50 % duty level from the divider; same clock domain, so no synchroniser.
- i_pause  input  1  level; while high, seconds ticks are ignored.
- i_clear  input  1  synchronous one-cycle clear of the time value to 00:00.
- o_seg  output  7  segment cathodes, active-low; bit0=a ... bit6=g.
- o_dp  output  1  decimal-point cathode, active-low.
- o_an  output  4  digit anodes, active-low; an[0]=seconds ones (rightmost) ... an[3]=minutes tens.
- o_wrap  output  1  one-cycle pulse when the time rolls over from 59:59 to 00:00.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - BCD digits = 0; refresh counter = 0; digit select = RESET_DIGIT; edge register = 0.
  - o_seg = 7'h7F, o_dp = 1, o_an = 4'hF (all dark), o_wrap = 0.
- Tick detect:
  - A tick is a rising edge of i_clk_1Hz: current level 1 AND registered previous level 0.
  - Since the edge register resets to 0, a high level at reset release counts as a tick.
  - One tick per second; falling edges are ignored.
- Counting priority, evaluated each cycle:
  1. i_clear: all digits become 0; o_wrap stays 0. Clear beats a coincident tick.
  2. Else if tick and !i_pause: increment the BCD value.
  3. Else: hold.
- Ticks arriving while paused are dropped, not queued.
- Clear while paused: value becomes 00:00 and remains paused.
- BCD rules:
  - sec_ones 0-9 carries into sec_tens 0-5, which carries into min_ones 0-9, which carries into min_tens 0-5.
  - 59:59 + tick gives 00:00, and o_wrap = 1 for exactly that one cycle.
  - Each digit is 4 bits; values above 9 are never produced.
- Multiplexing:
  - The refresh counter counts 0..REFRESH_COUNT-1 and wraps.
  - On its terminal value, digit select advances 0,1,2,3,0,...
- Output registers (one-cycle latency from digit select and BCD state to pins):
  - o_an: one-cold with the selected digit, e.g. digit 2 gives 4'b1011.
  - o_seg: encoding of the selected digit's BCD value.
  - o_dp: 0 only when digit 2 is selected and i_clk_1Hz is high; otherwise 1.
- First output cycle after reset release:
  - o_an = ~(1 << RESET_DIGIT).
  - o_seg = "0" = 7'b1000000.
- A count update is visible on the pins no later than the next time its digit is scanned.
- Reset asserted mid-operation:
  - All state and outputs return to reset values immediately.
  - No wrap pulse is generated.
- Segment codes, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble = 1111111 (blank).

Decomposition:
- Shared package `seg7_pkg`:
  - segment code constants for digits 0-9 and blank;
  - digit index constants DIG_SEC_ONES=0 .. DIG_MIN_TENS=3;
  - anode-all-off constant 4'hF.
- One sub-module, `bcd_to_seg7`:
  - combinational 4-bit BCD to 7-bit active-low segment code;
  - reused later by other display blocks.
- Counting, edge detect, refresh and output registers stay in mmss_display.

Test Plan (bench overrides REFRESH_COUNT=4; i_clk_1Hz driven as a slow toggle):
- Reset release with i_clk_1Hz=0 -> next cycle o_an=4'b1110, o_seg=7'b1000000, o_dp=1, o_wrap=0; after 4 cycles o_an=4'b1101.
- 75 rising edges of i_clk_1Hz -> digits read 01:15; scanning digit 2 gives o_seg=7'b1111001 with o_dp=0 while i_clk_1Hz is high and o_dp=1 while it is low.
- Preload to 59:59 via 3599 edges, then 1 more edge -> 00:00 with o_wrap high for exactly 1 cycle.
- i_pause=1 across 5 edges -> value unchanged; deassert, then 1 edge -> increments by exactly 1.
- i_clear asserted in the same cycle as a tick at 00:09 -> 00:00, o_wrap=0.
- i_rst_n pulsed low for 3 ns between clock edges at 12:34 -> outputs dark at once (o_an=4'hF, o_seg=7'h7F) without a clock edge; after release, counting restarts from 00:00.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment codes and digit/anode constants
package seg7_pkg;

  // Active-low cathode codes, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  localparam logic [3:0] AN_ALL_OFF = 4'hF;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-low segment code
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mmss_display.sv
// rtl/mmss_display.sv - BCD mm:ss counter on the 1 Hz input, multiplexed 4-digit display
module mmss_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_COUNT = 100_000,
  parameter int RESET_DIGIT   = 0
) (
  input  logic       i_clk_100MHz,
  input  logic       i_rst_n,
  input  logic       i_clk_1Hz,
  input  logic       i_pause,
  input  logic       i_clear,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [3:0] o_an,
  output logic       o_wrap
);

  localparam int CW = $clog2(REFRESH_COUNT);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_COUNT - 1);

  logic [3:0]    sec_ones, sec_tens, min_ones, min_tens;
  logic          prev_1hz;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_sel;
  logic [3:0]    sel_bcd;
  logic [6:0]    sel_seg;
  logic          tick;
  logic          at_max;

  // Edge register resets low, so a high level at reset release is a tick
  assign tick   = i_clk_1Hz & ~prev_1hz;
  assign at_max = (sec_ones == 4'd9) && (sec_tens == 4'd5) &&
                  (min_ones == 4'd9) && (min_tens == 4'd5);

  always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_1hz <= 1'b0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      o_wrap   <= 1'b0;
    end else begin
      prev_1hz <= i_clk_1Hz;
      o_wrap   <= 1'b0;
      if (i_clear) begin
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
        min_tens <= 4'd0;
      end else if (tick && !i_pause) begin
        o_wrap <= at_max;
        if (sec_ones != 4'd9) begin
          sec_ones <= sec_ones + 4'd1;
        end else begin
          sec_ones <= 4'd0;
          if (sec_tens != 4'd5) begin
            sec_tens <= sec_tens + 4'd1;
          end else begin
            sec_tens <= 4'd0;
            if (min_ones != 4'd9) begin
              min_ones <= min_ones + 4'd1;
            end else begin
              min_ones <= 4'd0;
              min_tens <= (min_tens != 4'd5) ? min_tens + 4'd1 : 4'd0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'(RESET_DIGIT);
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_sel   <= digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    sel_bcd = sec_ones;
    case (digit_sel)
      DIG_SEC_ONES: sel_bcd = sec_ones;
      DIG_SEC_TENS: sel_bcd = sec_tens;
      DIG_MIN_ONES: sel_bcd = min_ones;
      DIG_MIN_TENS: sel_bcd = min_tens;
      default:      sel_bcd = sec_ones;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (sel_bcd),
    .seg (sel_seg)
  );

  // Colon blink rides on the minutes-ones decimal point
  always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg <= SEG_BLANK;
      o_dp  <= 1'b1;
      o_an  <= AN_ALL_OFF;
    end else begin
      o_seg <= sel_seg;
      o_dp  <= !((digit_sel == DIG_MIN_ONES) && i_clk_1Hz);
      o_an  <= ~(4'b0001 << digit_sel);
    end
  end

endmodule

// File: tb/tb_mmss_display.sv
// tb/tb_mmss_display.sv - self-checking bench for mmss_display
module tb_mmss_display;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       c1 = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       wrap;

  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mmss_display #(.REFRESH_COUNT(R), .RESET_DIGIT(0)) dut (
    .i_clk_100MHz (clk),
    .i_rst_n      (rst_n),
    .i_clk_1Hz    (c1),
    .i_pause      (pause),
    .i_clear      (clear),
    .o_seg        (seg),
    .o_dp         (dp),
    .o_an         (an),
    .o_wrap       (wrap)
  );

  function automatic logic [6:0] seg_code(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Digit idx of elapsed time t seconds: 0=sec ones .. 3=min tens
  function automatic int digit_of(input int t, input int idx);
    int s, m;
    s = t % 60;
    m = t / 60;
    case (idx)
      0: return s % 10;
      1: return s / 10;
      2: return m % 10;
      default: return m / 10;
    endcase
  endfunction

  int         m_t, m_k, m_sel;
  bit         m_prev, m_valid, m_tick;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_k = 0; m_prev = 0; m_valid = 0;
    end else begin
      m_sel  = (m_k / R) % 4;
      e_an   = ~(4'b0001 << m_sel);
      e_seg  = seg_code(digit_of(m_t, m_sel));
      e_dp   = !(m_sel == 2 && c1);
      e_wrap = 1'b0;
      m_tick = c1 && !m_prev;
      if (clear) m_t = 0;
      else if (m_tick && !pause) begin
        if (m_t == 3599) begin m_t = 0; e_wrap = 1'b1; end
        else m_t = m_t + 1;
      end
      m_prev  = c1;
      m_k     = m_k + 1;
      m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] xa;
    logic [6:0] xs;
    logic       xd, xw;
    if (chk_en) begin
      xa = m_valid ? e_an : 4'hF;
      xs = m_valid ? e_seg : 7'h7F;
      xd = m_valid ? e_dp : 1'b1;
      xw = m_valid ? e_wrap : 1'b0;
      total++;
      if (an === xa && seg === xs && dp === xd && wrap === xw) passed++;
      else $display("FAIL cycle_cmp t=%0t an=%b exp %b seg=%b exp %b dp=%b exp %b wrap=%b exp %b",
                    $time, an, xa, seg, xs, dp, xd, wrap, xw);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge1();
    c1 = 1'b1; cyc(1);
    c1 = 1'b0; cyc(1);
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget);
    int n = 0;
    while (an !== target && n < budget) begin cyc(1); n++; end
    check("wait_an", int'(an), int'(target));
  endtask

  initial begin
    int wc;
    #1 rst_n = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    cyc(2);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);

    rst_n = 1'b1;
    cyc(1);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'b1000000);
    check("first_dp", dp, 1);
    check("first_wrap", wrap, 0);
    cyc(4);
    check("scan_an", an, 4'b1101);

    repeat (74) edge1();
    c1 = 1'b1;
    cyc(1);
    check("model_75", m_t, 75);
    wait_an(4'b1011, 20);
    check("minones_seg_hi", seg, 7'b1111001);
    check("colon_on", dp, 0);
    c1 = 1'b0;
    cyc(1);
    wait_an(4'b1011, 20);
    check("minones_seg_lo", seg, 7'b1111001);
    check("colon_off", dp, 1);

    clear = 1'b1; cyc(1); clear = 1'b0;
    check("model_clr", m_t, 0);
    repeat (3599) edge1();
    check("model_5959", m_t, 3599);
    cyc(16);
    c1 = 1'b1;
    wc = 0;
    repeat (8) begin cyc(1); if (wrap === 1'b1) wc++; end
    check("wrap_pulses", wc, 1);
    check("model_wrap0", m_t, 0);
    c1 = 1'b0;
    cyc(16);

    repeat (3) edge1();
    pause = 1'b1;
    repeat (5) edge1();
    cyc(16);
    check("model_paused", m_t, 3);
    pause = 1'b0;
    edge1();
    cyc(16);
    check("model_unpaused", m_t, 4);

    repeat (5) edge1();
    check("model_9", m_t, 9);
    c1 = 1'b1; clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clr_tick_wrap", wrap, 0);
    check("model_clr_tick", m_t, 0);
    c1 = 1'b0;
    cyc(16);
    wait_an(4'b1110, 20);
    check("clr_tick_seg", seg, 7'b1000000);

    repeat (754) edge1();
    cyc(16);
    check("model_1234", m_t, 754);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_dp", dp, 1);
    check("async_wrap", wrap, 0);
    #2 rst_n = 1'b1;
    cyc(3);
    check("model_restart", m_t, 0);
    repeat (2) edge1();
    cyc(16);
    wait_an(4'b1110, 20);
    check("restart_seg", seg, 7'b0100100);
    cyc(8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
